// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the 64-bit data memory (optional MISALIGN_TRAP_EN)
module dmem_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [DATA_W-1:0] depth_w = DATA_W'(DEPTH);
  state_t state;
  logic last, id, we_l, fault_l;
  logic win1, sel_we, sel_fault, misalign;
  logic [DATA_W-1:0] sel_addr, sel_wdata;
`ifdef MISALIGN_TRAP_EN
  assign misalign = sel_addr[2:0] != 3'b000;
`else
  assign misalign = 1'b0;
`endif
  // pick the winner: a lone request wins, ties go to port 0 or to the port not served last
  always_comb begin
    win1 = req1 & (~req0 | ((FIXED_PRIO == 1'b0) & ~last));
    sel_we = win1 ? we1 : we0;
    sel_addr = win1 ? addr1 : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    sel_fault = ((sel_addr >> 3) >= depth_w) | misalign;
  end
  // three-state sequencer with every output registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      id <= 1'b0;
      we_l <= 1'b0;
      fault_l <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err <= 1'b0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          state <= ACCESS;
          busy <= 1'b1;
          id <= win1;
          last <= win1;
          we_l <= sel_we;
          fault_l <= sel_fault;
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          gnt0 <= ~win1;
          gnt1 <= win1;
          mem_write <= sel_we & ~sel_fault;
          mem_read <= ~sel_we & ~sel_fault;
        end
        ACCESS: begin
          state <= RESP;
          rdata <= fault_l ? '0 : (we_l ? rdata : mem_rdata);
          rvalid0 <= ~id;
          rvalid1 <= id;
          err <= fault_l;
        end
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven transactions plus round-robin and reset-in-access sequences
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err, busy, mem_write, mem_read;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic fgnt0, fgnt1, frvalid0, frvalid1, ferr, fbusy, fmem_write, fmem_read;
  logic [63:0] frdata, fmem_addr, fmem_wdata;
  logic [63:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(64), .DEPTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata));

  dmem_arbiter #(.DATA_W(64), .DEPTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(fgnt0), .gnt1(fgnt1), .rvalid0(frvalid0), .rvalid1(frvalid1),
    .rdata(frdata), .err(ferr), .busy(fbusy), .mem_addr(fmem_addr),
    .mem_wdata(fmem_wdata), .mem_write(fmem_write), .mem_read(fmem_read),
    .mem_rdata(64'h0));

  // memory model: index by the low word bits so a leaked faulting store would hit word 0
  assign mem_rdata = mem[mem_addr[7:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;

  typedef struct {
    logic r0, r1, w0, w1;
    logic [63:0] a0, a1, d0, d1;
    logic port, e, chk_rd;
    logic [63:0] rd;
  } vec_t;
  vec_t tv[12];

  function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                              logic [63:0] a0, logic [63:0] a1, logic [63:0] d0, logic [63:0] d1,
                              logic port, logic e, logic chk_rd, logic [63:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.port = port; v.e = e; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, " gnt0"}, gnt0, 1'b0);
    chk1({tag, " gnt1"}, gnt1, 1'b0);
    chk1({tag, " rvalid0"}, rvalid0, 1'b0);
    chk1({tag, " rvalid1"}, rvalid1, 1'b0);
    chk1({tag, " err"}, err, 1'b0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " mem_write"}, mem_write, 1'b0);
    chk1({tag, " mem_read"}, mem_read, 1'b0);
    chk({tag, " rdata"}, rdata, 64'h0);
    chk({tag, " mem_addr"}, mem_addr, 64'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 64'h0);
  endtask

  task automatic run(input vec_t v, input int n);
    logic w;
    logic [63:0] a, d;
    string t;
    t = $sformatf("vec%0d", n);
    w = v.port ? v.w1 : v.w0;
    a = v.port ? v.a1 : v.a0;
    d = v.port ? v.d1 : v.d0;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(negedge clk);
    chk1({t, " gnt0"}, gnt0, ~v.port);
    chk1({t, " gnt1"}, gnt1, v.port);
    chk1({t, " busy"}, busy, 1'b1);
    chk1({t, " mem_write"}, mem_write, w & ~v.e);
    chk1({t, " mem_read"}, mem_read, ~w & ~v.e);
    if (!v.e) chk({t, " mem_addr"}, mem_addr, a);
    if (!v.e && w) chk({t, " mem_wdata"}, mem_wdata, d);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk1({t, " rvalid0"}, rvalid0, ~v.port);
    chk1({t, " rvalid1"}, rvalid1, v.port);
    chk1({t, " err"}, err, v.e);
    if (v.chk_rd) chk({t, " rdata"}, rdata, v.rd);
    chk1({t, " resp mem_write"}, mem_write, 1'b0);
    chk1({t, " resp mem_read"}, mem_read, 1'b0);
    chk1({t, " resp gnt"}, gnt0 | gnt1, 1'b0);
    @(negedge clk);
    chk1({t, " idle busy"}, busy, 1'b0);
    chk1({t, " idle rvalid"}, rvalid0 | rvalid1, 1'b0);
    chk1({t, " idle err"}, err, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
    tv[0]  = mk(1, 0, 1, 0, 64'h10, 64'h0, 64'hAB, 64'h0, 0, 0, 0, 64'h0);
    tv[1]  = mk(0, 1, 0, 0, 64'h0, 64'h10, 64'h0, 64'h0, 1, 0, 1, 64'hAB);
    tv[2]  = mk(0, 1, 0, 1, 64'h0, 64'h08, 64'h0, 64'h1111, 1, 0, 0, 64'h0);
    tv[3]  = mk(1, 0, 1, 0, 64'h00, 64'h0, 64'h5555, 64'h0, 0, 0, 0, 64'h0);
    tv[4]  = mk(1, 0, 1, 0, 64'h100, 64'h0, 64'hDEAD, 64'h0, 0, 1, 1, 64'h0);
    tv[5]  = mk(1, 0, 0, 0, 64'h00, 64'h0, 64'h0, 64'h0, 0, 0, 1, 64'h5555);
`ifdef MISALIGN_TRAP_EN
    tv[6]  = mk(1, 0, 0, 0, 64'h0C, 64'h0, 64'h0, 64'h0, 0, 1, 1, 64'h0);
`else
    tv[6]  = mk(1, 0, 0, 0, 64'h0C, 64'h0, 64'h0, 64'h0, 0, 0, 1, 64'h1111);
`endif
    tv[7]  = mk(1, 1, 0, 0, 64'h10, 64'h08, 64'h0, 64'h0, 1, 0, 1, 64'h1111);
    tv[8]  = mk(1, 1, 0, 0, 64'h10, 64'h08, 64'h0, 64'h0, 0, 0, 1, 64'hAB);
    tv[9]  = mk(0, 1, 0, 0, 64'h0, 64'hFFF8, 64'h0, 64'h0, 1, 1, 1, 64'h0);
    tv[10] = mk(0, 1, 0, 1, 64'h0, 64'hF8, 64'h0, 64'h77, 1, 0, 0, 64'h0);
    tv[11] = mk(1, 0, 0, 0, 64'hF8, 64'h0, 64'h0, 64'h0, 0, 0, 1, 64'h77);

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;
    for (int i = 0; i < 12; i++) run(tv[i], i);

    // round-robin vs fixed priority with both requests held
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 64'h0; addr1 = 64'h08;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk1($sformatf("rr gnt0 k%0d", k), gnt0, (k % 3 == 0) && ((k / 3) % 2 == 0));
      chk1($sformatf("rr gnt1 k%0d", k), gnt1, (k % 3 == 0) && ((k / 3) % 2 == 1));
      chk1($sformatf("fp gnt0 k%0d", k), fgnt0, k % 3 == 0);
      chk1($sformatf("fp gnt1 k%0d", k), fgnt1, 1'b0);
      if (k == 11) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end

    // reset landing in the ACCESS cycle of a store
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h18; wdata0 = 64'h99;
    @(negedge clk);
    chk1("rst gnt0", gnt0, 1'b1);
    chk1("rst access mem_write", mem_write, 1'b1);
    reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst1");
    @(negedge clk);
    chk_idle_outputs("rst2");
    reset = 1'b1;
    run(mk(0, 1, 0, 0, 64'h0, 64'h10, 64'h0, 64'h0, 1, 0, 1, 64'hAB), 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
